// File: rtl/rom_arbiter_pkg.sv
// rom_arbiter_pkg: shared ROM bus widths and arbiter state encoding
package rom_arbiter_pkg;
    localparam int ROM_ADDR_W = 11;
    localparam int ROM_DATA_W = 32;
    typedef enum logic [1:0] {IDLE, READ, LATCH, DONE} state_t;
endpackage

// File: rtl/rom_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin select, favouring the master not granted last on a tie
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic       grant
);
    always_comb grant = (&req) ? ~ptr : req[1];
endmodule

// File: rtl/rom_arbiter.sv
// rom_arbiter: shares one registered single-port ROM between two masters, one read at a time
module rom_arbiter
    import rom_arbiter_pkg::*;
#(
    parameter int ADDR_W = ROM_ADDR_W,
    parameter int DATA_W = ROM_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    output logic              m0_rdy,
    output logic [DATA_W-1:0] m0_rd_data,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    output logic              m1_rdy,
    output logic [DATA_W-1:0] m1_rd_data,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              busy,
    output logic              gnt
);
    state_t state;
    logic   ptr;
    logic   sel;
    rr_arb2 u_rr (.req({m1_req, m0_req}), .ptr(ptr), .grant(sel));
    assign busy = state != IDLE;
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            rom_addr   <= '0;
            m0_rdy     <= 1'b0;
            m1_rdy     <= 1'b0;
            m0_rd_data <= '0;
            m1_rd_data <= '0;
            gnt        <= 1'b0;
            ptr        <= 1'b1;
        end else begin
            case (state)
                IDLE: if (m0_req || m1_req) begin
                    gnt      <= sel;
                    ptr      <= sel;
                    rom_addr <= sel ? m1_addr : m0_addr;
                    state    <= READ;
                end
                READ: state <= LATCH;
                LATCH: begin
                    if (gnt) begin
                        m1_rd_data <= rom_data;
                        m1_rdy     <= 1'b1;
                    end else begin
                        m0_rd_data <= rom_data;
                        m0_rdy     <= 1'b1;
                    end
                    state <= DONE;
                end
                DONE: begin
                    m0_rdy <= 1'b0;
                    m1_rdy <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: directed and random reads against a transaction-level arbitration model
module tb_rom_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_req = 1'b0, m1_req = 1'b0;
    logic [10:0] m0_addr = '0, m1_addr = '0;
    logic        m0_rdy, m1_rdy, busy, gnt;
    logic [31:0] m0_rd_data, m1_rd_data, rom_data;
    logic [10:0] rom_addr;
    logic [31:0] mem [2048];
    logic [31:0] exp_data [2];
    int          last = 1;
    int          n_assert = 0, n_fail = 0;
    int          cnt0 = 0, cnt1 = 0, both_hi = 0;

    rom_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_rdy(m0_rdy), .m0_rd_data(m0_rd_data),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_rdy(m1_rdy), .m1_rd_data(m1_rd_data),
        .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy), .gnt(gnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rom_data <= mem[rom_addr];
    always @(negedge clk) begin
        if (m0_rdy) cnt0++;
        if (m1_rdy) cnt1++;
        if (m0_rdy && m1_rdy) both_hi++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic r0, input logic r1);
        return (r0 && r1) ? 1 - last : (r1 ? 1 : 0);
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        step();
        chk("rst_busy", busy, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_rdy0", m0_rdy, 0);
        chk("rst_rdy1", m1_rdy, 0);
        chk("rst_data0", m0_rd_data, 0);
        chk("rst_data1", m1_rd_data, 0);
        reset = 1'b0;
        exp_data[0] = '0;
        exp_data[1] = '0;
        last = 1;
    endtask

    // One whole transaction from the IDLE sampling edge; requests must already be driven
    task automatic do_txn(input bit drop);
        int m;
        logic [10:0] a;
        m = pick(m0_req, m1_req);
        a = m ? m1_addr : m0_addr;
        last = m;
        step();
        chk("grant_busy", busy, 1);
        chk("grant_gnt", gnt, 32'(m));
        chk("grant_rom_addr", rom_addr, 32'(a));
        if (drop) begin
            if (m == 1) begin m1_req = 1'b0; m1_addr = ~a; end
            else begin m0_req = 1'b0; m0_addr = ~a; end
        end
        step();
        chk("read_rdy", 32'({m1_rdy, m0_rdy}), 0);
        chk("read_rom_addr", rom_addr, 32'(a));
        step();
        exp_data[m] = mem[a];
        chk("latch_rdy0", m0_rdy, 32'(m == 0));
        chk("latch_rdy1", m1_rdy, 32'(m == 1));
        chk("latch_data0", m0_rd_data, exp_data[0]);
        chk("latch_data1", m1_rd_data, exp_data[1]);
        step();
        chk("done_rdy", 32'({m1_rdy, m0_rdy}), 0);
        chk("done_busy", busy, 0);
        chk("done_rom_addr", rom_addr, 32'(a));
    endtask

    initial begin
        int c0, c1;
        for (int i = 0; i < 2048; i++) mem[i] = $urandom;
        mem[4] = 32'h1234_5678;
        step();
        do_reset();

        // single read of address 4
        m0_req = 1'b1; m0_addr = 11'h004;
        do_txn(0);
        chk("single_data", m0_rd_data, 32'h1234_5678);
        m0_req = 1'b0;
        step();
        chk("idle_busy", busy, 0);

        // simultaneous after reset: master 0 first
        do_reset();
        m0_req = 1'b1; m0_addr = 11'h010;
        m1_req = 1'b1; m1_addr = 11'h7FF;
        do_txn(0);
        chk("sim_first", m0_rd_data, mem[11'h010]);
        m0_req = 1'b0;
        do_txn(0);
        chk("sim_second", m1_rd_data, mem[11'h7FF]);
        m1_req = 1'b0;
        step();

        // fairness with both held
        c0 = cnt0; c1 = cnt1;
        m0_req = 1'b1; m1_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            m0_addr = 11'($urandom); m1_addr = 11'($urandom);
            chk("fair_pick", 32'(pick(1'b1, 1'b1)), 32'(i % 2 == 0 ? 0 : 1));
            do_txn(0);
        end
        chk("fair_cnt0", 32'(cnt0 - c0), 4);
        chk("fair_cnt1", 32'(cnt1 - c1), 4);
        m0_req = 1'b0; m1_req = 1'b0;
        step();

        // withdrawal after grant
        m1_req = 1'b1; m1_addr = 11'h155;
        do_txn(1);
        chk("wd_data", m1_rd_data, mem[11'h155]);
        step();
        chk("wd_no_second", busy, 0);

        // reset while in LATCH aborts the read
        c0 = cnt0;
        m0_req = 1'b1; m0_addr = 11'h0AA;
        step();
        step();
        reset = 1'b1;
        step();
        chk("abort_rdy", 32'({m1_rdy, m0_rdy}), 0);
        chk("abort_busy", busy, 0);
        chk("abort_data0", m0_rd_data, 0);
        chk("abort_data1", m1_rd_data, 0);
        chk("abort_rom_addr", rom_addr, 0);
        chk("abort_no_pulse", 32'(cnt0 - c0), 0);
        reset = 1'b0;
        exp_data[0] = '0; exp_data[1] = '0; last = 1;
        do_txn(0);
        chk("abort_retry", m0_rd_data, mem[11'h0AA]);

        // held request re-issues immediately
        m0_addr = 11'h001;
        do_txn(0);
        do_txn(0);
        chk("held_data", m0_rd_data, mem[11'h001]);
        m0_req = 1'b0;
        step();

        // random traffic
        for (int i = 0; i < 40; i++) begin
            m0_req = 1'($urandom); m1_req = 1'($urandom);
            m0_addr = 11'($urandom); m1_addr = 11'($urandom);
            if (m0_req || m1_req) do_txn($urandom_range(0, 3) == 0);
            else begin
                step();
                chk("rand_idle", busy, 0);
            end
        end
        m0_req = 1'b0; m1_req = 1'b0;
        step();
        chk("never_both_rdy", 32'(both_hi), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
